// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slave_mem
//  Purpose  : AXI4 slave backed by an internal word-addressed memory.
//             Independent read and write channels. One outstanding burst
//             per direction. INCR and FIXED bursts are supported; WRAP and
//             the reserved encoding are handled as INCR. AxSIZE is ignored,
//             so every beat is full width.
//  Revision : 1.0 - initial release
//
//  Build option:
//    AXI_SLAVE_DECERR_EN - when defined, word addresses >= MEM_DEPTH return
//                          DECERR, their writes are dropped and their read
//                          data is zero. When undefined, word addresses wrap
//                          modulo MEM_DEPTH.
//
//  Ports:
//    ACLK, ARESETN                        clock, async active-low reset
//    AW*  (ID/ADDR/LEN/SIZE/BURST/VALID)  write address in, AWREADY out
//    W*   (DATA/STRB/LAST/VALID)          write data in, WREADY out
//    B*   (ID/RESP/VALID)                 write response out, BREADY in
//    AR*  (ID/ADDR/LEN/SIZE/BURST/VALID)  read address in, ARREADY out
//    R*   (ID/DATA/RESP/LAST/VALID)       read data out, RREADY in
// ============================================================================
module axi_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // write address
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int WORD_WIDTH = ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;

`ifdef AXI_SLAVE_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  // Word address falls outside the array (only meaningful with DECERR_EN;
  // otherwise the index simply uses the low bits and aliases).
  function automatic logic out_of_range(input logic [WORD_WIDTH-1:0] word);
    return DECERR_EN && ({1'b0, word} >= (WORD_WIDTH+1)'(MEM_DEPTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane offset bits and the size fields carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, ARSIZE, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

  wr_state_t             wr_state, wr_state_nxt;
  logic [ID_WIDTH-1:0]   wr_id, wr_id_nxt;
  logic [WORD_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic [7:0]            wr_len, wr_len_nxt, wr_beat, wr_beat_nxt;
  logic                  wr_fixed, wr_fixed_nxt;
  logic                  wr_slverr, wr_slverr_nxt, wr_decerr, wr_decerr_nxt;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]            bresp_nxt;
  logic [ID_WIDTH-1:0]   bid_nxt;
  logic                  aw_hs, w_hs, b_hs, wr_final, wr_oob;

  assign aw_hs    = AWVALID && AWREADY;
  assign w_hs     = WVALID && WREADY;
  assign b_hs     = BVALID && BREADY;
  assign wr_final = (wr_beat == wr_len);
  assign wr_oob   = out_of_range(wr_addr);

  always_comb begin
    wr_state_nxt  = wr_state;
    wr_id_nxt     = wr_id;
    wr_addr_nxt   = wr_addr;
    wr_len_nxt    = wr_len;
    wr_beat_nxt   = wr_beat;
    wr_fixed_nxt  = wr_fixed;
    wr_slverr_nxt = wr_slverr;
    wr_decerr_nxt = wr_decerr;
    bresp_nxt     = BRESP;
    bid_nxt       = BID;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs) begin
          wr_id_nxt     = AWID;
          wr_addr_nxt   = AWADDR[ADDR_WIDTH-1:ADDR_LSB];
          wr_len_nxt    = AWLEN;
          wr_fixed_nxt  = (AWBURST == BURST_FIXED);
          wr_beat_nxt   = 8'd0;
          wr_slverr_nxt = 1'b0;
          wr_decerr_nxt = 1'b0;
          wr_state_nxt  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          // Burst length comes from AWLEN; WLAST is only cross-checked.
          if (WLAST != wr_final) wr_slverr_nxt = 1'b1;
          if (wr_oob)            wr_decerr_nxt = 1'b1;
          if (!wr_fixed)         wr_addr_nxt   = wr_addr + WORD_WIDTH'(1);
          wr_beat_nxt = wr_beat + 8'd1;
          if (wr_final) begin
            wr_state_nxt = W_RESP;
            bid_nxt      = wr_id;
            if (wr_decerr_nxt)      bresp_nxt = RESP_DECERR;
            else if (wr_slverr_nxt) bresp_nxt = RESP_SLVERR;
            else                    bresp_nxt = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (b_hs) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
    // Handshake outputs are registered from the next state, which keeps the
    // readies low during reset and raises them on the first edge after it.
    awready_nxt = (wr_state_nxt == W_IDLE);
    wready_nxt  = (wr_state_nxt == W_DATA);
    bvalid_nxt  = (wr_state_nxt == W_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state  <= W_IDLE;
      wr_id     <= '0;
      wr_addr   <= '0;
      wr_len    <= '0;
      wr_beat   <= '0;
      wr_fixed  <= 1'b0;
      wr_slverr <= 1'b0;
      wr_decerr <= 1'b0;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= '0;
      BID       <= '0;
    end else begin
      wr_state  <= wr_state_nxt;
      wr_id     <= wr_id_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_len    <= wr_len_nxt;
      wr_beat   <= wr_beat_nxt;
      wr_fixed  <= wr_fixed_nxt;
      wr_slverr <= wr_slverr_nxt;
      wr_decerr <= wr_decerr_nxt;
      AWREADY   <= awready_nxt;
      WREADY    <= wready_nxt;
      BVALID    <= bvalid_nxt;
      BRESP     <= bresp_nxt;
      BID       <= bid_nxt;
    end
  end

  // Memory array has no reset; contents survive ARESETN.
  always_ff @(posedge ACLK) begin
    if (w_hs && !wr_oob) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (WSTRB[b]) mem[wr_addr[IDX_WIDTH-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  rd_state_t             rd_state, rd_state_nxt;
  logic [WORD_WIDTH-1:0] rd_addr, rd_addr_nxt, rd_word;
  logic [7:0]            rd_len, rd_len_nxt, rd_beat, rd_beat_nxt;
  logic                  rd_fixed, rd_fixed_nxt;
  logic                  rd_load, rd_oob;
  logic                  arready_nxt, rvalid_nxt, rlast_nxt;
  logic [1:0]            rresp_nxt;
  logic [ID_WIDTH-1:0]   rid_nxt;
  logic                  ar_hs, r_hs;

  assign ar_hs  = ARVALID && ARREADY;
  assign r_hs   = RVALID && RREADY;
  assign rd_oob = out_of_range(rd_word);

  // rd_word is the word fetched into RDATA when rd_load is set; rd_addr
  // tracks the word currently presented on the R channel.
  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_len_nxt   = rd_len;
    rd_beat_nxt  = rd_beat;
    rd_fixed_nxt = rd_fixed;
    rlast_nxt    = RLAST;
    rresp_nxt    = RRESP;
    rid_nxt      = RID;
    rd_word      = rd_addr;
    rd_load      = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ar_hs) begin
          rd_word      = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
          rd_load      = 1'b1;
          rd_addr_nxt  = rd_word;
          rd_len_nxt   = ARLEN;
          rd_fixed_nxt = (ARBURST == BURST_FIXED);
          rd_beat_nxt  = 8'd0;
          rlast_nxt    = (ARLEN == 8'd0);
          rid_nxt      = ARID;
          rresp_nxt    = rd_oob ? RESP_DECERR : RESP_OKAY;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (RLAST) begin
            rd_state_nxt = R_IDLE;
          end else begin
            rd_word     = rd_fixed ? rd_addr : rd_addr + WORD_WIDTH'(1);
            rd_load     = 1'b1;
            rd_addr_nxt = rd_word;
            rd_beat_nxt = rd_beat + 8'd1;
            rlast_nxt   = (rd_beat_nxt == rd_len);
            rresp_nxt   = rd_oob ? RESP_DECERR : RESP_OKAY;
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
    arready_nxt = (rd_state_nxt == R_IDLE);
    rvalid_nxt  = (rd_state_nxt == R_DATA);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state <= R_IDLE;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_fixed <= 1'b0;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RLAST    <= 1'b0;
      RRESP    <= '0;
      RID      <= '0;
      RDATA    <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_addr  <= rd_addr_nxt;
      rd_len   <= rd_len_nxt;
      rd_beat  <= rd_beat_nxt;
      rd_fixed <= rd_fixed_nxt;
      ARREADY  <= arready_nxt;
      RVALID   <= rvalid_nxt;
      RLAST    <= rlast_nxt;
      RRESP    <= rresp_nxt;
      RID      <= rid_nxt;
      // Array read sees pre-edge contents, so a same-cycle write to the
      // same word is not forwarded.
      if (rd_load) RDATA <= rd_oob ? '0 : mem[rd_word[IDX_WIDTH-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_slave_mem
//  Purpose  : Self-checking bench for axi_slave_mem. Stimulus tasks push the
//             expected B / R responses into queues; a monitor pops and
//             compares them on every B / R handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_slave_mem;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = 3'd2;
  logic [1:0]  AWBURST = INCR;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = 3'd2;
  logic [1:0]  ARBURST = INCR;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;

  axi_slave_mem dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  logic [31:0] ebuf [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: B/R handshakes complete at the posedge following this negedge,
  // since inputs only change shortly after posedges.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", 64'(BVALID), 64'(0));
        end else begin
          b_exp_t e;
          e = b_q.pop_front();
          check("bid", 64'(BID), 64'(e.id));
          check("bresp", 64'(BRESP), 64'(e.resp));
        end
      end
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 64'(RVALID), 64'(0));
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          check("rid", 64'(RID), 64'(e.id));
          check("rdata", 64'(RDATA), 64'(e.data));
          check("rresp", 64'(RRESP), 64'(e.resp));
          check("rlast", 64'(RLAST), 64'(e.last));
        end
      end
    end
  end

  // wlast_mode: 0 = correct, 1 = low on every beat, 2 = high on every beat
  task automatic write_issue(input logic [3:0] tid, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int wlast_mode, input logic [1:0] exp);
    int n;
    b_q.push_back(b_exp_t'{id: tid, resp: exp});
    AWID = tid; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!AWREADY && n < 50);
    check("awready_wait", 64'(AWREADY), 64'(1));
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA = wbuf[i]; WSTRB = sbuf[i]; WVALID = 1'b1;
      WLAST = (wlast_mode == 1) ? 1'b0 : (wlast_mode == 2) ? 1'b1 : (i == len);
      n = 0;
      do begin @(negedge ACLK); n++; end while (!WREADY && n < 50);
      check("wready_wait", 64'(WREADY), 64'(1));
      @(posedge ACLK); #1;
      WVALID = 1'b0; WLAST = 1'b0;
    end
  endtask

  task automatic write_wait_b();
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(BVALID && BREADY) && n < 50);
    check("b_wait", 64'(BVALID), 64'(1));
    @(posedge ACLK); #1;
  endtask

  task automatic write_burst(input logic [3:0] tid, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int wlast_mode, input logic [1:0] exp);
    write_issue(tid, addr, len, burst, wlast_mode, exp);
    write_wait_b();
  endtask

  task automatic read_issue(input logic [3:0] tid, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [1:0] exp);
    int n;
    for (int i = 0; i <= len; i++)
      r_q.push_back(r_exp_t'{id: tid, data: ebuf[i], resp: exp, last: (i == len)});
    ARID = tid; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!ARREADY && n < 50);
    check("arready_wait", 64'(ARREADY), 64'(1));
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  // exp_cycles > 0 checks first-beat latency plus back-to-back beats.
  task automatic read_wait(input int exp_cycles);
    int n;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(RVALID && RREADY && RLAST) && n < 100);
    check("r_done", 64'(RVALID && RLAST), 64'(1));
    if (exp_cycles > 0) check("r_cycles", 64'(n), 64'(exp_cycles));
    @(posedge ACLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) sbuf[i] = 4'hF;

    // ---- reset state ----
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'(0));
    check("rst_arready", 64'(ARREADY), 64'(0));
    check("rst_wready",  64'(WREADY),  64'(0));
    check("rst_bvalid",  64'(BVALID),  64'(0));
    check("rst_rvalid",  64'(RVALID),  64'(0));
    check("rst_rdata",   64'(RDATA),   64'(0));
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("rel_awready_0", 64'(AWREADY), 64'(0));
    @(negedge ACLK);
    check("rel_awready_1", 64'(AWREADY), 64'(1));
    check("rel_arready_1", 64'(ARREADY), 64'(1));
    @(posedge ACLK); #1;

    // ---- single write / read ----
    wbuf[0] = 32'hDEADBEEF;
    write_burst(4'h1, 32'h10, 0, INCR, 0, OKAY);
    ebuf[0] = 32'hDEADBEEF;
    read_issue(4'h2, 32'h10, 0, INCR, OKAY);
    read_wait(1);

    // ---- INCR burst ----
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); ebuf[i] = 32'(i + 1); end
    write_burst(4'h3, 32'h100, 3, INCR, 0, OKAY);
    read_issue(4'h4, 32'h100, 3, INCR, OKAY);
    read_wait(4);

    // ---- byte strobes ----
    wbuf[0] = 32'h11223344;
    write_burst(4'h5, 32'h200, 0, INCR, 0, OKAY);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'h5;
    write_burst(4'h5, 32'h200, 0, INCR, 0, OKAY);
    sbuf[0] = 4'hF;
    ebuf[0] = 32'h11BB33DD;
    read_issue(4'h6, 32'h200, 0, INCR, OKAY);
    read_wait(1);

    // ---- FIXED burst: all beats land on one word ----
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    write_burst(4'h7, 32'h300, 2, FIXED, 0, OKAY);
    ebuf[0] = 32'hC; ebuf[1] = 32'hC;
    read_issue(4'h8, 32'h300, 1, FIXED, OKAY);
    read_wait(2);

    // ---- backpressure ----
    wbuf[0] = 32'h55; wbuf[1] = 32'h66;
    BREADY = 1'b0;
    write_issue(4'h9, 32'h400, 1, INCR, 0, OKAY);
    repeat (3) begin
      @(negedge ACLK);
      check("bp_bvalid", 64'(BVALID), 64'(1));
      check("bp_bid", 64'(BID), 64'(4'h9));
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    write_wait_b();
    ebuf[0] = 32'h55; ebuf[1] = 32'h66;
    RREADY = 1'b0;
    read_issue(4'hA, 32'h400, 1, INCR, OKAY);
    repeat (5) begin
      @(negedge ACLK);
      check("bp_rvalid", 64'(RVALID), 64'(1));
      check("bp_rdata", 64'(RDATA), 64'(32'h55));
      check("bp_rid", 64'(RID), 64'(4'hA));
      check("bp_rlast", 64'(RLAST), 64'(0));
    end
    @(posedge ACLK); #1;
    RREADY = 1'b1;
    read_wait(0);

    // ---- WLAST protocol errors ----
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    write_burst(4'hB, 32'h500, 1, INCR, 1, SLVERR);
    write_burst(4'hC, 32'h500, 1, INCR, 2, SLVERR);

    // ---- address beyond MEM_DEPTH (word 1024) ----
    wbuf[0] = 32'hCAFEF00D;
    write_burst(4'hD, 32'h0, 0, INCR, 0, OKAY);
`ifdef AXI_SLAVE_DECERR_EN
    ebuf[0] = 32'h0;
    read_issue(4'hE, 32'h1000, 0, INCR, DECERR);
`else
    ebuf[0] = 32'hCAFEF00D;
    read_issue(4'hE, 32'h1000, 0, INCR, OKAY);
`endif
    read_wait(1);

    // ---- reset mid-burst ----
    for (int i = 0; i < 4; i++) ebuf[i] = 32'(i + 1);
    read_issue(4'h6, 32'h100, 3, INCR, OKAY);
    @(negedge ACLK); @(negedge ACLK); @(negedge ACLK);  // beat 2 on the bus
    #2;
    ARESETN = 1'b0;
    r_q.delete();
    #1;
    check("mid_rst_rvalid", 64'(RVALID), 64'(0));
    check("mid_rst_arready", 64'(ARREADY), 64'(0));
    check("mid_rst_rlast", 64'(RLAST), 64'(0));
    check("mid_rst_rid", 64'(RID), 64'(0));
    check("mid_rst_rdata", 64'(RDATA), 64'(0));
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("mid_rel_arready_0", 64'(ARREADY), 64'(0));
    @(negedge ACLK);
    check("mid_rel_arready_1", 64'(ARREADY), 64'(1));
    @(posedge ACLK); #1;
    read_issue(4'h7, 32'h100, 3, INCR, OKAY);
    read_wait(4);

    repeat (2) @(posedge ACLK);
    check("b_queue_empty", 64'(b_q.size()), 64'(0));
    check("r_queue_empty", 64'(r_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
